// File: rtl/riscv_hart.sv
// Multi-cycle RV32I hart: FETCH -> EXEC -> (LOAD) -> FETCH.
// Talks to a 1-cycle synchronous instruction ROM and word-wide data RAM.
module riscv_hart #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  input  logic [XLEN-1:0]       mem_read,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_data,
  output logic                  mem_write
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] pc_q, next_pc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            ld_rd;
  logic [2:0]            ld_f3;
  logic [XLEN-1:0]       regs [32];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic       f7b;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign f3     = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];
  assign f7b    = instruction[30];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = XLEN'($signed(instruction[31:20]));
  assign imm_s = XLEN'($signed({instruction[31:25],
                                instruction[11:7]}));
  assign imm_b = XLEN'($signed({instruction[31],
                                instruction[7],
                                instruction[30:25],
                                instruction[11:8],
                                1'b0}));
  assign imm_u = XLEN'($signed({instruction[31:12],
                                12'b0}));
  assign imm_j = XLEN'($signed({instruction[31],
                                instruction[19:12],
                                instruction[20],
                                instruction[30:21],
                                1'b0}));

  logic is_lui, is_auipc, is_jal, is_jalr;
  logic is_branch, is_load, is_store;
  logic is_opimm, is_op;

  assign is_lui    = opcode == 7'h37;
  assign is_auipc  = opcode == 7'h17;
  assign is_jal    = opcode == 7'h6f;
  assign is_jalr   = opcode == 7'h67;
  assign is_branch = opcode == 7'h63;
  assign is_load   = opcode == 7'h03;
  assign is_store  = opcode == 7'h23;
  assign is_opimm  = opcode == 7'h13;
  assign is_op     = opcode == 7'h33;

  logic [XLEN-1:0] rv1, rv2;

  assign rv1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rv2 = (rs2 == 5'd0) ? '0 : regs[rs2];

  logic [XLEN-1:0] alu_b, alu_y;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq;

  assign alu_b = is_op ? rv2 : imm_i;
  assign shamt = alu_b[4:0];
  assign lt_s  = $signed(rv1) < $signed(alu_b);
  assign lt_u  = rv1 < alu_b;
  assign eq    = rv1 == rv2;

  always_comb begin
    alu_y = '0;
    case (f3)
      3'b000: alu_y = (is_op && f7b) ? rv1 - alu_b
                                     : rv1 + alu_b;
      3'b001: alu_y = rv1 << shamt;
      3'b010: alu_y = XLEN'(lt_s);
      3'b011: alu_y = XLEN'(lt_u);
      3'b100: alu_y = rv1 ^ alu_b;
      3'b101: alu_y = f7b ? XLEN'($signed(rv1) >>> shamt)
                          : rv1 >> shamt;
      3'b110: alu_y = rv1 | alu_b;
      default: alu_y = rv1 & alu_b;
    endcase
  end

  // Branches compare rs1 against rs2, not the immediate.
  logic br_lt_s, br_lt_u, taken;

  assign br_lt_s = $signed(rv1) < $signed(rv2);
  assign br_lt_u = rv1 < rv2;

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000: taken = eq;
      3'b001: taken = !eq;
      3'b100: taken = br_lt_s;
      3'b101: taken = !br_lt_s;
      3'b110: taken = br_lt_u;
      3'b111: taken = !br_lt_u;
      default: taken = 1'b0;
    endcase
  end

  logic [15:0]     lane;
  logic [XLEN-1:0] ld_val;

  assign lane = 16'(mem_read >> {addr_q[1:0], 3'b000});

  always_comb begin
    ld_val = mem_read;
    case (ld_f3)
      3'b000: ld_val = XLEN'($signed(lane[7:0]));
      3'b001: ld_val = XLEN'($signed(lane));
      3'b100: ld_val = XLEN'(lane[7:0]);
      3'b101: ld_val = XLEN'(lane);
      default: ld_val = mem_read;
    endcase
  end

  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [XLEN-1:0]       ea_i, ea_s;
  logic                  wr_en;
  logic [4:0]            wr_rd;
  logic [XLEN-1:0]       wr_data;

  assign pc_inc = pc_q + ADDR_WIDTH'(4);
  assign ea_i   = rv1 + imm_i;
  assign ea_s   = rv1 + imm_s;

  always_comb begin
    next_state = state;
    next_pc    = pc_q;
    wr_en      = 1'b0;
    wr_rd      = rd;
    wr_data    = '0;
    mem_addr   = '0;
    mem_data   = '0;
    mem_write  = 1'b0;
    case (state)
      FETCH: next_state = EXEC;
      EXEC: begin
        next_state = FETCH;
        next_pc    = pc_inc;
        unique case (1'b1)
          is_lui: begin
            wr_en   = 1'b1;
            wr_data = imm_u;
          end
          is_auipc: begin
            wr_en   = 1'b1;
            wr_data = XLEN'(pc_q) + imm_u;
          end
          is_jal: begin
            wr_en   = 1'b1;
            wr_data = XLEN'(pc_inc);
            next_pc = pc_q + ADDR_WIDTH'(imm_j);
          end
          is_jalr: begin
            wr_en   = 1'b1;
            wr_data = XLEN'(pc_inc);
            next_pc = ADDR_WIDTH'(ea_i & ~XLEN'(1));
          end
          is_branch: begin
            if (taken)
              next_pc = pc_q + ADDR_WIDTH'(imm_b);
          end
          is_load: begin
            mem_addr   = ADDR_WIDTH'(ea_i);
            next_state = LOAD;
            next_pc    = pc_q;
          end
          is_store: begin
            // Word-only RAM: SB/SH retire without writing.
            if (f3 == 3'b010) begin
              mem_addr  = ADDR_WIDTH'(ea_s);
              mem_data  = rv2;
              mem_write = 1'b1;
            end
          end
          is_opimm, is_op: begin
            wr_en   = 1'b1;
            wr_data = alu_y;
          end
          default: ;
        endcase
      end
      LOAD: begin
        mem_addr   = addr_q;
        wr_en      = 1'b1;
        wr_rd      = ld_rd;
        wr_data    = ld_val;
        next_pc    = pc_inc;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= FETCH;
      pc_q   <= '0;
      addr_q <= '0;
      ld_rd  <= '0;
      ld_f3  <= '0;
    end else begin
      state <= next_state;
      pc_q  <= next_pc;
      if (state == EXEC && is_load) begin
        addr_q <= ADDR_WIDTH'(ea_i);
        ld_rd  <= rd;
        ld_f3  <= f3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
    end else if (wr_en && wr_rd != 5'd0) begin
      regs[wr_rd] <= wr_data;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_riscv_hart.sv
// Directed bench for riscv_hart: small programs run for an exact clock count,
// then data RAM words are compared against hand-computed values.
module tb_riscv_hart;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_write;

  riscv_hart dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_write   (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [64];
  logic [31:0] ram [64];
  logic        ram_init;

  always @(posedge clk) instruction <= rom[pc[7:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++)
        ram[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_write) begin
      ram[mem_addr[7:2]] <= mem_data;
    end
    mem_read <= ram[mem_addr[7:2]];
  end

  function automatic logic [31:0] enc_i(logic [31:0] imm, int rs1,
                                        int f3, int rd, logic [6:0] op);
    logic [4:0] a, d;
    logic [2:0] f;
    a = rs1[4:0]; d = rd[4:0]; f = f3[2:0];
    return {imm[11:0], a, f, d, op};
  endfunction

  function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1,
                                        int f3, int rd);
    logic [4:0] a, b, d;
    logic [2:0] f;
    a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0]; f = f3[2:0];
    return {f7, b, a, f, d, 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(logic [31:0] imm, int rs2,
                                        int rs1, int f3);
    logic [4:0] a, b;
    logic [2:0] f;
    a = rs1[4:0]; b = rs2[4:0]; f = f3[2:0];
    return {imm[11:5], b, a, f, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(logic [31:0] imm, int rs2,
                                        int rs1, int f3);
    logic [4:0] a, b;
    logic [2:0] f;
    a = rs1[4:0]; b = rs2[4:0]; f = f3[2:0];
    return {imm[12], imm[10:5], b, a, f, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_u(logic [31:0] imm20, int rd,
                                        logic [6:0] op);
    logic [4:0] d;
    d = rd[4:0];
    return {imm20[19:0], d, op};
  endfunction

  function automatic logic [31:0] enc_j(logic [31:0] imm, int rd);
    logic [4:0] d;
    d = rd[4:0];
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'h6f};
  endfunction

  typedef struct packed {
    logic [7:0][31:0] prog;
    logic [5:0]       n;
    logic [2:0]       nchk;
    logic [3:0][5:0]  idx;
    logic [3:0][31:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic load_prog(vec_t v);
    for (int i = 0; i < 64; i++)
      rom[i] = 32'h0;
    for (int i = 0; i < 8; i++)
      rom[i] = v.prog[i];
  endtask

  task automatic start(vec_t v);
    rst = 1'b0;
    @(negedge clk);
    load_prog(v);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst      = 1'b1;
    ram_init = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 32'h0;
      ram[i] = 32'h0;
    end
    for (int v = 0; v < NV; v++)
      vecs[v] = '0;

    // add, store
    vecs[0].prog[0] = enc_i(5, 0, 0, 1, 7'h13);
    vecs[0].prog[1] = enc_i(7, 0, 0, 2, 7'h13);
    vecs[0].prog[2] = enc_r(7'h00, 2, 1, 0, 3);
    vecs[0].prog[3] = enc_s(0, 3, 0, 2);
    vecs[0].n = 8; vecs[0].nchk = 1;
    vecs[0].idx[0] = 0; vecs[0].exp[0] = 32'h0000_000C;

    // lui/addi/sub
    vecs[1].prog[0] = enc_u(32'h12345, 1, 7'h37);
    vecs[1].prog[1] = enc_i(32'h678, 1, 0, 1, 7'h13);
    vecs[1].prog[2] = enc_r(7'h20, 1, 0, 0, 2);
    vecs[1].prog[3] = enc_s(4, 1, 0, 2);
    vecs[1].prog[4] = enc_s(8, 2, 0, 2);
    vecs[1].n = 10; vecs[1].nchk = 2;
    vecs[1].idx[0] = 1; vecs[1].exp[0] = 32'h1234_5678;
    vecs[1].idx[1] = 2; vecs[1].exp[1] = 32'hEDCB_A988;

    // bne loop
    vecs[2].prog[0] = enc_i(3, 0, 0, 1, 7'h13);
    vecs[2].prog[1] = enc_i(2, 2, 0, 2, 7'h13);
    vecs[2].prog[2] = enc_i(-1, 1, 0, 1, 7'h13);
    vecs[2].prog[3] = enc_b(-8, 0, 1, 1);
    vecs[2].prog[4] = enc_s(0, 2, 0, 2);
    vecs[2].n = 22; vecs[2].nchk = 1;
    vecs[2].idx[0] = 0; vecs[2].exp[0] = 32'h6;

    // lbu / lw
    vecs[3].prog[0] = enc_i(-1, 0, 0, 1, 7'h13);
    vecs[3].prog[1] = enc_s(12, 1, 0, 2);
    vecs[3].prog[2] = enc_i(12, 0, 4, 2, 7'h03);
    vecs[3].prog[3] = enc_i(12, 0, 2, 3, 7'h03);
    vecs[3].prog[4] = enc_s(16, 2, 0, 2);
    vecs[3].prog[5] = enc_s(20, 3, 0, 2);
    vecs[3].n = 14; vecs[3].nchk = 2;
    vecs[3].idx[0] = 4; vecs[3].exp[0] = 32'h0000_00FF;
    vecs[3].idx[1] = 5; vecs[3].exp[1] = 32'hFFFF_FFFF;

    // jal skip, x0 write discarded
    vecs[4].prog[0] = enc_j(8, 1);
    vecs[4].prog[1] = enc_i(1, 0, 0, 5, 7'h13);
    vecs[4].prog[2] = enc_s(0, 1, 0, 2);
    vecs[4].prog[3] = enc_s(4, 5, 0, 2);
    vecs[4].prog[4] = enc_i(9, 0, 0, 0, 7'h13);
    vecs[4].prog[5] = enc_s(8, 0, 0, 2);
    vecs[4].n = 10; vecs[4].nchk = 3;
    vecs[4].idx[0] = 0; vecs[4].exp[0] = 32'h4;
    vecs[4].idx[1] = 1; vecs[4].exp[1] = 32'h0;
    vecs[4].idx[2] = 2; vecs[4].exp[2] = 32'h0;

    // srai / srli / slti on a negative value
    vecs[5].prog[0] = enc_i(-16, 0, 0, 1, 7'h13);
    vecs[5].prog[1] = enc_i(32'h402, 1, 5, 2, 7'h13);
    vecs[5].prog[2] = enc_i(28, 1, 5, 3, 7'h13);
    vecs[5].prog[3] = enc_i(0, 1, 2, 4, 7'h13);
    vecs[5].prog[4] = enc_s(0, 2, 0, 2);
    vecs[5].prog[5] = enc_s(4, 3, 0, 2);
    vecs[5].prog[6] = enc_s(8, 4, 0, 2);
    vecs[5].n = 14; vecs[5].nchk = 3;
    vecs[5].idx[0] = 0; vecs[5].exp[0] = 32'hFFFF_FFFC;
    vecs[5].idx[1] = 1; vecs[5].exp[1] = 32'h0000_000F;
    vecs[5].idx[2] = 2; vecs[5].exp[2] = 32'h0000_0001;

    // jalr with rd==rs1 and odd target, auipc
    vecs[6].prog[0] = enc_u(0, 1, 7'h17);
    vecs[6].prog[1] = enc_i(16, 1, 0, 1, 7'h13);
    vecs[6].prog[2] = enc_i(1, 1, 0, 1, 7'h67);
    vecs[6].prog[3] = enc_i(99, 0, 0, 7, 7'h13);
    vecs[6].prog[4] = enc_s(0, 1, 0, 2);
    vecs[6].prog[5] = enc_u(1, 2, 7'h17);
    vecs[6].prog[6] = enc_s(4, 2, 0, 2);
    vecs[6].n = 12; vecs[6].nchk = 2;
    vecs[6].idx[0] = 0; vecs[6].exp[0] = 32'h0000_000C;
    vecs[6].idx[1] = 1; vecs[6].exp[1] = 32'h0000_1014;

    // lb/lh lanes, sb does not write
    vecs[7].prog[0] = enc_u(32'h8765F, 1, 7'h37);
    vecs[7].prog[1] = enc_i(32'h0C3, 1, 0, 1, 7'h13);
    vecs[7].prog[2] = enc_s(24, 1, 0, 2);
    vecs[7].prog[3] = enc_i(25, 0, 0, 2, 7'h03);
    vecs[7].prog[4] = enc_i(26, 0, 1, 3, 7'h03);
    vecs[7].prog[5] = enc_s(28, 1, 0, 0);
    vecs[7].prog[6] = enc_s(32, 2, 0, 2);
    vecs[7].prog[7] = enc_s(36, 3, 0, 2);
    vecs[7].n = 18; vecs[7].nchk = 4;
    vecs[7].idx[0] = 6; vecs[7].exp[0] = 32'h8765_F0C3;
    vecs[7].idx[1] = 7; vecs[7].exp[1] = 32'hA5A5_0007;
    vecs[7].idx[2] = 8; vecs[7].exp[2] = 32'hFFFF_FFF0;
    vecs[7].idx[3] = 9; vecs[7].exp[3] = 32'hFFFF_8765;

    // bltu not taken, blt taken on -1 vs 1
    vecs[8].prog[0] = enc_i(-1, 0, 0, 1, 7'h13);
    vecs[8].prog[1] = enc_i(1, 0, 0, 2, 7'h13);
    vecs[8].prog[2] = enc_b(8, 2, 1, 6);
    vecs[8].prog[3] = enc_i(1, 3, 0, 3, 7'h13);
    vecs[8].prog[4] = enc_b(8, 2, 1, 4);
    vecs[8].prog[5] = enc_i(16, 3, 0, 3, 7'h13);
    vecs[8].prog[6] = enc_s(0, 3, 0, 2);
    vecs[8].n = 12; vecs[8].nchk = 1;
    vecs[8].idx[0] = 0; vecs[8].exp[0] = 32'h1;

    #2 rst = 1'b0;
    #1;
    check("reset pc", pc, 32'h0);
    check("reset mem_write", 32'(mem_write), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);

    for (int v = 0; v < NV; v++) begin
      start(vecs[v]);
      repeat (int'(vecs[v].n)) @(posedge clk);
      #1;
      for (int k = 0; k < int'(vecs[v].nchk); k++)
        check($sformatf("v%0d mem[%0d]", v, vecs[v].idx[k]),
              ram[vecs[v].idx[k]], vecs[v].exp[k]);
    end

    // reset asserted during EXEC of the store
    start(vecs[0]);
    repeat (7) @(posedge clk);
    #1;
    check("store exec mem_write", 32'(mem_write), 32'h1);
    check("store exec mem_data", mem_data, 32'h0000_000C);
    check("store exec mem_addr", mem_addr, 32'h0);
    #2 rst = 1'b0;
    #1;
    check("mid-store rst mem_write", 32'(mem_write), 32'h0);
    check("mid-store rst mem_data", mem_data, 32'h0);
    check("mid-store rst pc", pc, 32'h0);
    @(posedge clk);
    #1;
    check("dropped store mem[0]", ram[0], 32'hA5A5_0000);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rerun mem[0]", ram[0], 32'h0000_000C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
